// File: rtl/xalu_nibble_seq.sv
// Nibble-serial sequencer for the 4-bit xalu slice: runs one 16-bit operation
// over four clocks and collects the result, carry and status flags.
module xalu_nibble_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        com,
  input  logic        cin,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        zero,
  output logic        neg_zero,
  output logic        equ,
  output logic [3:0]  slice_a,
  output logic [3:0]  slice_b,
  output logic [2:0]  slice_f,
  output logic        slice_ci_right,
  output logic        slice_ci_left,
  output logic        slice_com,
  input  logic [3:0]  slice_d,
  input  logic        slice_co_left,
  input  logic        slice_co_right,
  input  logic        slice_equ
);

  // state   | meaning
  // IDLE    | waiting for start, slice inputs held at 0
  // RUN     | stepping nibbles s=0..3 through the slice
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  logic        state_q;
  logic [1:0]  s_q;
  logic [15:0] a_q, b_q;
  logic [2:0]  op_q;
  logic        com_q;
  logic        c_q, c_d;
  logic [15:0] acc_q, acc_d;
  logic        eq_q, eq_d;
  logic [15:0] result_q;
  logic        cout_q, zero_q, neg_zero_q, equ_q, done_q;

  logic [1:0]  n;
  logic [3:0]  nib_a, nib_b;
  logic        running;
  logic        is_right_carry, is_shr;

  assign running        = (state_q == ST_RUN);
  assign is_shr         = (op_q == OP_SHR);
  assign is_right_carry = (op_q == OP_ADD) || (op_q == OP_SHL);

  // SHR walks MSB first so the shifted-in bit enters at the top nibble.
  assign n = is_shr ? (2'd3 - s_q) : s_q;

  always_comb begin
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
    case (n)
      2'd0: begin nib_a = a_q[3:0];   nib_b = b_q[3:0];   end
      2'd1: begin nib_a = a_q[7:4];   nib_b = b_q[7:4];   end
      2'd2: begin nib_a = a_q[11:8];  nib_b = b_q[11:8];  end
      default: begin nib_a = a_q[15:12]; nib_b = b_q[15:12]; end
    endcase
  end

  assign slice_a        = running ? nib_a : 4'd0;
  assign slice_b        = running ? nib_b : 4'd0;
  assign slice_f        = running ? op_q  : 3'd0;
  assign slice_com      = running & com_q;
  assign slice_ci_right = running & is_right_carry & c_q;
  assign slice_ci_left  = running & is_shr & c_q;

  always_comb begin
    c_d = c_q;
    if (is_right_carry)
      c_d = slice_co_left;
    else if (is_shr)
      c_d = slice_co_right;
  end

  always_comb begin
    acc_d = acc_q;
    case (n)
      2'd0:    acc_d[3:0]   = slice_d;
      2'd1:    acc_d[7:4]   = slice_d;
      2'd2:    acc_d[11:8]  = slice_d;
      default: acc_d[15:12] = slice_d;
    endcase
  end

  assign eq_d = eq_q & slice_equ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s_q        <= 2'd0;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      op_q       <= 3'd0;
      com_q      <= 1'b0;
      c_q        <= 1'b0;
      acc_q      <= 16'd0;
      eq_q       <= 1'b0;
      result_q   <= 16'd0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_zero_q <= 1'b0;
      equ_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            op_q    <= op;
            com_q   <= com;
            c_q     <= cin;
            acc_q   <= 16'd0;
            eq_q    <= 1'b1;
            s_q     <= 2'd0;
            state_q <= ST_RUN;
          end
        end
        default: begin
          acc_q <= acc_d;
          eq_q  <= eq_d;
          c_q   <= c_d;
          s_q   <= s_q + 2'd1;
          if (s_q == 2'd3) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b1;
            result_q   <= acc_d;
            zero_q     <= (acc_d == 16'h0000);
            neg_zero_q <= (acc_d == 16'hFFFF);
            equ_q      <= eq_d;
            cout_q     <= (is_right_carry || is_shr) ? c_d : 1'b0;
          end
        end
      endcase
    end
  end

  assign busy     = running;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign neg_zero = neg_zero_q;
  assign equ      = equ_q;

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Bench for xalu_nibble_seq: behavioural 4-bit slice, vector table, scoreboard
// and hand-written handshake/reset sequences.
module tb_xalu_nibble_seq;

  logic        clk, rst_n, start;
  logic [2:0]  op;
  logic        com, cin;
  logic [15:0] a_in, b_in;
  logic        busy, done, cout, zero, neg_zero, equ;
  logic [15:0] result;
  logic [3:0]  slice_a, slice_b, slice_d;
  logic [2:0]  slice_f;
  logic        slice_ci_right, slice_ci_left, slice_com;
  logic        slice_co_left, slice_co_right, slice_equ;

  xalu_nibble_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .com(com), .cin(cin),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
    .cout(cout), .zero(zero), .neg_zero(neg_zero), .equ(equ),
    .slice_a(slice_a), .slice_b(slice_b), .slice_f(slice_f),
    .slice_ci_right(slice_ci_right), .slice_ci_left(slice_ci_left),
    .slice_com(slice_com), .slice_d(slice_d), .slice_co_left(slice_co_left),
    .slice_co_right(slice_co_right), .slice_equ(slice_equ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural xalu slice
  logic [4:0] sum5;
  logic [3:0] raw;
  always_comb begin
    sum5 = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_ci_right};
    raw = 4'd0;
    slice_co_left = 1'b0;
    slice_co_right = 1'b0;
    case (slice_f)
      3'd0: begin raw = sum5[3:0]; slice_co_left = sum5[4]; end
      3'd1: raw = slice_a & slice_b;
      3'd2: raw = slice_a | slice_b;
      3'd3: raw = slice_a ^ slice_b;
      3'd4: raw = slice_a;
      3'd5: raw = slice_b;
      3'd6: begin raw = {slice_ci_left, slice_a[3:1]}; slice_co_right = slice_a[0]; end
      default: begin raw = {slice_a[2:0], slice_ci_right}; slice_co_left = slice_a[3]; end
    endcase
    slice_d = slice_com ? ~raw : raw;
    slice_equ = (slice_a == slice_b);
  end

  typedef struct {
    logic [2:0]  op;
    logic        com;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cout;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        equ;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic [15:0] res, input logic co,
                                  input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.res = res;
    e.cout = co;
    e.zero = (res == 16'h0000);
    e.neg = (res == 16'hFFFF);
    e.equ = (a == b);
    return e;
  endfunction

  // Word-level reference for randomised vectors
  function automatic exp_t model(input logic [2:0] o, input logic cm, input logic ci,
                                 input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic co;
    co = 1'b0;
    s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    case (o)
      3'd0: begin r = s[15:0]; co = s[16]; end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = a;
      3'd5: r = b;
      3'd6: begin r = {ci, a[15:1]}; co = a[0]; end
      default: begin r = {a[14:0], ci}; co = a[15]; end
    endcase
    if (cm) r = ~r;
    return mk_exp(r, co, a, b);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got done=1, expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_cout", cout, e.cout);
        chk("sb_zero", zero, e.zero);
        chk("sb_neg_zero", neg_zero, e.neg);
        chk("sb_equ", equ, e.equ);
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input vec_t v, input exp_t e);
    int lat;
    @(negedge clk);
    op = v.op; com = v.com; cin = v.cin; a_in = v.a; b_in = v.b; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    wait_done(lat);
    chk("latency", lat, 4);
  endtask

  vec_t tbl[12];
  vec_t v;
  int lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0};
    tbl[1]  = '{3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    tbl[2]  = '{3'd7, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'h0003, 1'b1};
    tbl[3]  = '{3'd6, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h4000, 1'b1};
    tbl[4]  = '{3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'hC000, 1'b1};
    tbl[5]  = '{3'd3, 1'b1, 1'b0, 16'h1234, 16'h1234, 16'hFFFF, 1'b0};
    tbl[6]  = '{3'd3, 1'b1, 1'b0, 16'h1234, 16'h1235, 16'hFFFE, 1'b0};
    tbl[7]  = '{3'd1, 1'b0, 1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    tbl[8]  = '{3'd2, 1'b0, 1'b0, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0};
    tbl[9]  = '{3'd4, 1'b0, 1'b1, 16'hABCD, 16'h1111, 16'hABCD, 1'b0};
    tbl[10] = '{3'd5, 1'b0, 1'b0, 16'hABCD, 16'h5A5A, 16'h5A5A, 1'b0};
    tbl[11] = '{3'd0, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'hCCCB, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 3'd0; com = 1'b0; cin = 1'b0;
    a_in = 16'd0; b_in = 16'd0;
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, zero, neg_zero, equ}, 0);
    chk("rst_slice", {slice_a, slice_b, slice_f, slice_ci_right, slice_ci_left, slice_com}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(tbl[i], mk_exp(tbl[i].res, tbl[i].cout, tbl[i].a, tbl[i].b));

    for (int i = 0; i < 8; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.com = 1'($urandom_range(0, 1));
      v.cin = 1'($urandom_range(0, 1));
      v.a = 16'($urandom);
      v.b = (i == 3) ? v.a : 16'($urandom);
      v.res = 16'd0; v.cout = 1'b0;
      run_op(v, model(v.op, v.com, v.cin, v.a, v.b));
    end

    @(negedge clk);
    chk("idle_slice", {slice_a, slice_b, slice_f, slice_ci_right, slice_ci_left, slice_com}, 0);

    // start held high; operand changes while busy must be ignored
    op = 3'd0; com = 1'b0; cin = 1'b0; a_in = 16'h0001; b_in = 16'h0001; start = 1'b1;
    sb.push_back(mk_exp(16'h0002, 1'b0, 16'h0001, 16'h0001));
    @(posedge clk); #1;
    chk("hs_busy", busy, 1);
    a_in = 16'h7777; b_in = 16'h7070;
    wait_done(lat);
    chk("hs_latency", lat, 4);
    // start still high on the done cycle: back-to-back acceptance
    a_in = 16'h0005; b_in = 16'h0003;
    sb.push_back(mk_exp(16'h0008, 1'b0, 16'h0005, 16'h0003));
    @(posedge clk); #1;
    chk("hs_done_pulse", done, 0);
    chk("b2b_busy", busy, 1);
    a_in = 16'hFFFF;
    start = 1'b0;
    wait_done(lat);
    chk("b2b_latency", lat, 4);

    // reset in the middle of an operation
    @(negedge clk);
    op = 3'd0; a_in = 16'h1234; b_in = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_slice", {slice_a, slice_b, slice_f}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{3'd0, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0};
    run_op(v, mk_exp(16'h0007, 1'b0, 16'h0003, 16'h0004));

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
